// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two one-entry buffers (ALU, load unit) merged onto one RF write port.
// Define RF_WB_RR_EN for round-robin on different-rd contention; default is fixed priority to A.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hz1,
  output logic        hz2,
  output logic [15:0] wr_cnt
);

  logic        a_full, b_full;
  logic [4:0]  a_rd_q, b_rd_q;
  logic [31:0] a_data_q, b_data_q;
  logic        older_b;
  logic        grant_a, grant_b;
  logic        a_load, b_load;
  logic        a_full_nxt, b_full_nxt;
  logic        contend_diff;
`ifdef RF_WB_RR_EN
  logic        rr_ptr_b;
`endif

  assign contend_diff = a_full & b_full & (a_rd_q != b_rd_q);

  // Equal-rd contention is resolved by age so the final RF value follows acceptance order.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full && b_full) begin
      if (a_rd_q == b_rd_q) begin
        grant_a = ~older_b;
        grant_b = older_b;
      end else begin
`ifdef RF_WB_RR_EN
        grant_a = ~rr_ptr_b;
        grant_b = rr_ptr_b;
`else
        grant_a = 1'b1;
`endif
      end
    end else begin
      grant_a = a_full;
      grant_b = b_full;
    end
  end

  assign a_ready    = ~a_full | grant_a;
  assign b_ready    = ~b_full | grant_b;
  assign a_load     = a_valid & a_ready & (a_rd != 5'd0);
  assign b_load     = b_valid & b_ready & (b_rd != 5'd0);
  assign a_full_nxt = a_load | (a_full & ~grant_a);
  assign b_full_nxt = b_load | (b_full & ~grant_b);

  assign hz1 = (rs1 != 5'd0) &&
               ((a_full && a_rd_q == rs1) || (b_full && b_rd_q == rs1) || (rf_we && rf_rd == rs1));
  assign hz2 = (rs2 != 5'd0) &&
               ((a_full && a_rd_q == rs2) || (b_full && b_rd_q == rs2) || (rf_we && rf_rd == rs2));

  always_ff @(posedge clk) begin
    if (rst) begin
      a_full   <= 1'b0;
      b_full   <= 1'b0;
      a_rd_q   <= 5'd0;
      b_rd_q   <= 5'd0;
      a_data_q <= 32'd0;
      b_data_q <= 32'd0;
      older_b  <= 1'b0;
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_data  <= 32'd0;
      wr_cnt   <= 16'd0;
`ifdef RF_WB_RR_EN
      rr_ptr_b <= 1'b0;
`endif
    end else begin
      a_full <= a_full_nxt;
      b_full <= b_full_nxt;
      if (a_load) begin
        a_rd_q   <= a_rd;
        a_data_q <= a_data;
      end
      if (b_load) begin
        b_rd_q   <= b_rd;
        b_data_q <= b_data;
      end

      // Age only matters while both entries are full; simultaneous loads make A older.
      if (a_load && b_load)
        older_b <= 1'b0;
      else if (a_load && b_full_nxt)
        older_b <= 1'b1;
      else if (b_load && a_full_nxt)
        older_b <= 1'b0;

      rf_we <= grant_a | grant_b;
      if (grant_a) begin
        rf_rd   <= a_rd_q;
        rf_data <= a_data_q;
      end else if (grant_b) begin
        rf_rd   <= b_rd_q;
        rf_data <= b_data_q;
      end

      if (rf_we && wr_cnt != 16'hFFFF)
        wr_cnt <= wr_cnt + 16'd1;

`ifdef RF_WB_RR_EN
      if (contend_diff)
        rr_ptr_b <= ~rr_ptr_b;
`endif
    end
  end

`ifndef RF_WB_RR_EN
  logic unused_contend;
  assign unused_contend = contend_diff;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter; expected sequences switch on RF_WB_RR_EN.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, rs1, rs2, rf_rd;
  logic [31:0] a_data, b_data, rf_data;
  logic        rf_we, hz1, hz2;
  logic [15:0] wr_cnt;
  logic [4:0]  exp_rd;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .rs1(rs1), .rs2(rs2), .hz1(hz1), .hz2(hz2), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b1; a_rd = 5'd6; a_data = 32'h66;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0; rs1 = 5'd6; rs2 = 5'd0;
    step(); step();
    rst = 1'b0; idle(); #1;
    check_val("rst_a_ready", 32'(a_ready), 32'd1);
    check_val("rst_b_ready", 32'(b_ready), 32'd1);
    check_val("rst_rf_we", 32'(rf_we), 32'd0);
    check_val("rst_rf_rd", 32'(rf_rd), 32'd0);
    check_val("rst_rf_data", rf_data, 32'd0);
    check_val("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    step();
    check_val("rst_ign_hz1", 32'(hz1), 32'd0);
    check_val("rst_ign_we", 32'(rf_we), 32'd0);

    // Uncontended A
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF; #1;
    check_val("unc_a_ready", 32'(a_ready), 32'd1);
    step(); idle();
    check_val("unc_we_c1", 32'(rf_we), 32'd0);
    step();
    check_val("unc_we_c2", 32'(rf_we), 32'd1);
    check_val("unc_rd_c2", 32'(rf_rd), 32'd5);
    check_val("unc_data_c2", rf_data, 32'hDEADBEEF);
    step();
    check_val("unc_we_c3", 32'(rf_we), 32'd0);
    check_val("unc_rd_hold", 32'(rf_rd), 32'd5);
    check_val("unc_wr_cnt", 32'(wr_cnt), 32'd1);

    // One-shot contention, different rd
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA3;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hB7; #1;
    check_val("con_b_ready0", 32'(b_ready), 32'd1);
    step(); idle(); #1;
    check_val("con_b_ready1", 32'(b_ready), 32'd0);
    check_val("con_a_ready1", 32'(a_ready), 32'd1);
    step();
    check_val("con_rd_first", 32'(rf_rd), 32'd3);
    check_val("con_b_ready2", 32'(b_ready), 32'd1);
    step();
    check_val("con_rd_second", 32'(rf_rd), 32'd7);
    check_val("con_data_second", rf_data, 32'hB7);
    check_val("con_we_second", 32'(rf_we), 32'd1);
    step();
    check_val("con_we_done", 32'(rf_we), 32'd0);

    // Sustained contention stream
    do_reset();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA3;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hB7;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef RF_WB_RR_EN
      exp_rd = (i % 2 == 0) ? 5'd3 : 5'd7;
`else
      exp_rd = 5'd3;
`endif
      check_val($sformatf("stream_rd_%0d", i), 32'(rf_rd), 32'(exp_rd));
    end
    idle();

    // WAW ordering on x9
    do_reset();
    a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h22;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'hBBBB0009;
    step();
    b_valid = 1'b0; a_rd = 5'd9; a_data = 32'hAAAA0009; #1;
    check_val("waw_a_ready1", 32'(a_ready), 32'd1);
    step(); idle(); #1;
    check_val("waw_rd_2", 32'(rf_rd), 32'd2);
    check_val("waw_a_ready2", 32'(a_ready), 32'd0);
    step();
    check_val("waw_rd_b", 32'(rf_rd), 32'd9);
    check_val("waw_data_b", rf_data, 32'hBBBB0009);
    step();
    check_val("waw_rd_a", 32'(rf_rd), 32'd9);
    check_val("waw_data_a", rf_data, 32'hAAAA0009);
    check_val("waw_we_a", 32'(rf_we), 32'd1);
    step();
    check_val("waw_wr_cnt", 32'(wr_cnt), 32'd3);

    // x0 discard and hazards
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h12345678; #1;
    check_val("x0_a_ready", 32'(a_ready), 32'd1);
    step(); idle();
    check_val("x0_we_c1", 32'(rf_we), 32'd0);
    step();
    check_val("x0_we_c2", 32'(rf_we), 32'd0);
    check_val("x0_wr_cnt", 32'(wr_cnt), 32'd3);
    rs1 = 5'd4; rs2 = 5'd5;
    a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h44; #1;
    check_val("hz1_pre", 32'(hz1), 32'd0);
    step(); idle(); #1;
    check_val("hz1_buf", 32'(hz1), 32'd1);
    check_val("hz2_other", 32'(hz2), 32'd0);
    step();
    check_val("hz1_rfwe", 32'(hz1), 32'd1);
    check_val("hz_rf_rd", 32'(rf_rd), 32'd4);
    step();
    check_val("hz1_after", 32'(hz1), 32'd0);
    rs1 = 5'd0; rs2 = 5'd0;

    // Reset mid-operation
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA3;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hB7;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; idle(); #1;
    check_val("mid_we0", 32'(rf_we), 32'd0);
    check_val("mid_wr_cnt", 32'(wr_cnt), 32'd0);
    check_val("mid_a_ready", 32'(a_ready), 32'd1);
    check_val("mid_b_ready", 32'(b_ready), 32'd1);
    step();
    check_val("mid_we1", 32'(rf_we), 32'd0);
    step();
    check_val("mid_we2", 32'(rf_we), 32'd0);

    // Counter saturation
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1;
    repeat (65534) step();
    idle();
    repeat (3) step();
    check_val("sat_fffe", 32'(wr_cnt), 32'h0000FFFE);
    a_valid = 1'b1;
    step(); idle();
    repeat (3) step();
    check_val("sat_ffff", 32'(wr_cnt), 32'h0000FFFF);
    a_valid = 1'b1;
    step(); idle();
    repeat (3) step();
    check_val("sat_hold", 32'(wr_cnt), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a_valid  in  1  requester A (ALU writeback) has a write
- a_ready  out  1  A write accepted this cycle when high with a_valid
- a_rd  in  5  A destination register
- a_data  in  32  A write data
- b_valid  in  1  requester B (load unit) has a write
- b_ready  out  1  B write accepted this cycle when high with b_valid
- b_rd  in  5  B destination register
- b_data  in  32  B write data
- rf_we  out  1  register-file write enable, registered
- rf_rd  out  5  register-file write address (drives Rd), registered
- rf_data  out  32  register-file write data (drives data_in), registered
- rs1  in  5  decode read address 1
- rs2  in  5  decode read address 2
- hz1  out  1  rs1 has a pending, unretired write
- hz2  out  1  rs2 has a pending, unretired write
- wr_cnt  out  16  count of retired writes, saturating

Function
REQ-003 Each requester SHALL own a one-entry holding buffer (full flag, rd, data); x_ready = ~x_full | grant_x, with no dependence on x_valid.
REQ-004 On x_valid & x_ready with x_rd != 0, the buffer SHALL load at the clock edge; with x_rd == 0, the write SHALL be accepted and discarded with no buffer load and no rf_we.
REQ-005 Each cycle the arbiter SHALL grant at most one full buffer; the granted entry drives rf_we=1/rf_rd/rf_data at the next edge and its buffer clears at that edge unless reloaded in the same cycle.
REQ-006 Latency SHALL be: accept at edge N, rf_we high in cycle N+1 at the earliest, register file written at edge N+2.
REQ-007 rf_we SHALL be 0 in any cycle following a cycle with no grant; rf_rd and rf_data SHALL hold their last values.
REQ-008 An age bit SHALL track which full buffer loaded first.
- When both buffers are full with equal rd, the older entry SHALL be granted first, overriding the policy in REQ-015.
- When both load in the same cycle, A SHALL be treated as older.
REQ-009 hz1 SHALL be 1 iff rs1 != 0 and rs1 equals the rd of a full buffer or rf_rd while rf_we=1; hz2 is the same for rs2. Both are combinational.
REQ-010 wr_cnt SHALL increment by 1 on each cycle with rf_we=1 and SHALL saturate at 16'hFFFF.
REQ-011 When both buffers are empty, a buffer loaded at edge N SHALL be grantable in cycle N+1, giving a sustained throughput of one write per cycle per requester when uncontended.

Reset
REQ-012 While rst=1 at a rising edge, the block SHALL clear both buffers and the age bit and set rf_we=0, rf_rd=0, rf_data=0, wr_cnt=0, and the round-robin pointer to A.
REQ-013 Reset mid-operation SHALL discard buffered writes without any rf_we pulse. a_ready and b_ready SHALL be 1 in the first cycle after reset.
REQ-014 Inputs SHALL be ignored in any cycle where rst=1.

Configuration
REQ-015 Macro RF_WB_RR_EN selects the arbitration policy for different-rd contention:
- Defined: round-robin. The pointer toggles to the non-granted requester after each contended grant.
- Undefined: fixed priority, with A always winning.
- REQ-008 applies in both cases.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Uncontended A: a_rd=5, a_data=32'hDEADBEEF accepted at edge 1 -> rf_we=1, rf_rd=5, rf_data=32'hDEADBEEF in cycle 2 only; wr_cnt=1.
- Contention, different rd: A rd=3 and B rd=7 accepted at the same edge.
  - RF_WB_RR_EN undefined: writes 3 then 7 on consecutive cycles, with b_ready=0 for one cycle.
  - RF_WB_RR_EN defined: a repeated contended stream alternates grants A,B,A,B.
- WAW ordering: B rd=9 accepted at edge 1 while A is busy, then A rd=9 -> B's data is written first and A's data is the final value of x9.
- x0 and hazards: A rd=0 -> accepted, no rf_we, wr_cnt unchanged. With rs1=4 and a buffered write to 4 -> hz1=1 until the cycle after rf_we for rd=4.
- Reset mid-operation: both buffers full, rst pulsed for one cycle -> no rf_we afterwards, wr_cnt=0, a_ready=b_ready=1. Separately, forcing wr_cnt to 16'hFFFF plus one more write -> wr_cnt stays 16'hFFFF.
